// File: rtl/snake_tick_scheduler.sv
// rtl/snake_tick_scheduler.sv - sub-tick/move-tick sequencer, turn arbiter and message-hold FSM for the snake datapath
// Optional key debounce filter is enabled with `define SNAKE_KEY_DEBOUNCE_EN.
module snake_tick_scheduler #(
    parameter int UNIT_CYCLES = 20000,
    parameter int DELAY_INIT  = 20,
    parameter int DELAY_MIN   = 10,
    parameter int BLINK_DIV   = 5,
    parameter int HOLD_TICKS  = 20,
    parameter int DELAY_W     = 8
) (
    input  logic               clockInp,
    input  logic               resetInp_n,
    input  logic [1:0]         KEY,
    input  logic               lose_evt,
    input  logic               win_evt,
    output logic               sub_tick,
    output logic               move_tick,
    output logic               turn_valid,
    output logic               turn_dir,
    output logic               msg_active,
    output logic               msg_clear,
    output logic [DELAY_W-1:0] delay_cur
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic {PLAY, HOLD} state_t;

    state_t             state;
    logic [UW-1:0]      unit_cnt;
    logic [DELAY_W-1:0] dly_cnt;
    logic [DELAY_W-1:0] dly_per;
    logic [BW-1:0]      blink_cnt;
    logic [HW-1:0]      hold_cnt;
    logic               lat_full;
    logic               lat_dir;

    logic [1:0] key_s1, key_s2, key_lvl, key_prev, key_fall;

    always_ff @(posedge clockInp) begin
        if (!resetInp_n) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
        end
    end

`ifdef SNAKE_KEY_DEBOUNCE_EN
    localparam int DEBOUNCE_SAMPLES = 50000;
    logic [15:0] stab_cnt [0:1];
    logic [1:0]  key_filt;

    // Count consecutive samples that disagree with the filtered level; adopt the new level once stable.
    always_ff @(posedge clockInp) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetInp_n) begin
                stab_cnt[i] <= '0;
                key_filt[i] <= 1'b1;
            end else if (key_s2[i] == key_filt[i]) begin
                stab_cnt[i] <= '0;
            end else if (stab_cnt[i] == 16'(DEBOUNCE_SAMPLES - 1)) begin
                stab_cnt[i] <= '0;
                key_filt[i] <= key_s2[i];
            end else begin
                stab_cnt[i] <= stab_cnt[i] + 16'd1;
            end
        end
    end
    assign key_lvl = key_filt;
`else
    assign key_lvl = key_s2;
`endif

    always_ff @(posedge clockInp) begin
        if (!resetInp_n) key_prev <= 2'b11;
        else             key_prev <= key_lvl;
    end

    assign key_fall = key_prev & ~key_lvl;

    logic unit_wrap, sub_fire, evt, move_fire, press, press_dir;

    always_comb begin
        unit_wrap = (unit_cnt == UW'(UNIT_CYCLES - 1));
        sub_fire  = unit_wrap && (dly_cnt == dly_per - DELAY_W'(1));
        evt       = (state == PLAY) && (lose_evt || win_evt);
        move_fire = sub_fire && (state == PLAY) && !evt && (blink_cnt == BW'(BLINK_DIV - 1));
        press     = |key_fall;
        press_dir = !key_fall[0];
    end

    always_ff @(posedge clockInp) begin
        if (!resetInp_n) begin
            state      <= PLAY;
            unit_cnt   <= '0;
            dly_cnt    <= '0;
            dly_per    <= DELAY_W'(DELAY_INIT);
            blink_cnt  <= '0;
            hold_cnt   <= '0;
            lat_full   <= 1'b0;
            lat_dir    <= 1'b0;
            sub_tick   <= 1'b0;
            move_tick  <= 1'b0;
            turn_valid <= 1'b0;
            turn_dir   <= 1'b0;
            msg_active <= 1'b0;
            msg_clear  <= 1'b0;
            delay_cur  <= DELAY_W'(DELAY_INIT);
        end else begin
            sub_tick   <= sub_fire;
            move_tick  <= move_fire;
            turn_valid <= move_fire && lat_full;
            msg_clear  <= 1'b0;
            if (move_fire && lat_full) turn_dir <= lat_dir;

            // The period length is sampled at each sub-tick so a delay change never cuts the current period short.
            if (sub_fire) begin
                unit_cnt <= '0;
                dly_cnt  <= '0;
                dly_per  <= delay_cur;
            end else if (unit_wrap) begin
                unit_cnt <= '0;
                dly_cnt  <= dly_cnt + DELAY_W'(1);
            end else begin
                unit_cnt <= unit_cnt + UW'(1);
            end

            case (state)
                PLAY: begin
                    if (evt) begin
                        state      <= HOLD;
                        msg_active <= 1'b1;
                        hold_cnt   <= '0;
                        blink_cnt  <= '0;
                        lat_full   <= 1'b0;
                        if (lose_evt)
                            delay_cur <= DELAY_W'(DELAY_INIT);
                        else if (delay_cur > DELAY_W'(DELAY_MIN))
                            delay_cur <= delay_cur - DELAY_W'(1);
                    end else begin
                        if (sub_fire)
                            blink_cnt <= move_fire ? '0 : blink_cnt + BW'(1);
                        // A press on the move cycle refills the latch that is being emptied.
                        if (press && (!lat_full || move_fire)) begin
                            lat_full <= 1'b1;
                            lat_dir  <= press_dir;
                        end else if (move_fire) begin
                            lat_full <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (sub_fire) begin
                        if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                            state      <= PLAY;
                            msg_active <= 1'b0;
                            msg_clear  <= 1'b1;
                            hold_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// tb/tb_snake_tick_scheduler.sv - table-driven bench for snake_tick_scheduler with small timing parameters
module tb_snake_tick_scheduler;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] KEY;
    logic       lose_evt, win_evt;
    logic       sub_tick, move_tick, turn_valid, turn_dir, msg_active, msg_clear;
    logic [7:0] delay_cur;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_tick_scheduler #(
        .UNIT_CYCLES(4), .DELAY_INIT(3), .DELAY_MIN(2),
        .BLINK_DIV(2), .HOLD_TICKS(3), .DELAY_W(8)
    ) dut (
        .clockInp   (clk),
        .resetInp_n (rstn),
        .KEY        (KEY),
        .lose_evt   (lose_evt),
        .win_evt    (win_evt),
        .sub_tick   (sub_tick),
        .move_tick  (move_tick),
        .turn_valid (turn_valid),
        .turn_dir   (turn_dir),
        .msg_active (msg_active),
        .msg_clear  (msg_clear),
        .delay_cur  (delay_cur)
    );

    // Inputs are applied before edge cyc; outputs are expected after edge cyc. KEY level persists.
    typedef struct {
        int         cyc;
        logic [1:0] key;
        logic       win, lose, rstn;
        logic       sub, mov, tv, td, ma, mc;
        logic [7:0] dly;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input int c, input logic [1:0] k, input logic w, input logic l, input logic r,
                       input logic s, input logic m, input logic tv, input logic td,
                       input logic ma, input logic mc, input logic [7:0] d);
        vec_t v;
        v.cyc = c; v.key = k; v.win = w; v.lose = l; v.rstn = r;
        v.sub = s; v.mov = m; v.tv = tv; v.td = td; v.ma = ma; v.mc = mc; v.dly = d;
        tbl.push_back(v);
    endtask

    initial begin
        int idx;
        int n, mt, tvc;
        logic [12:0] got, exp;

        //    cyc  key    w  l  r   sub mov tv td ma mc dly
        add(  11, 2'b11, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  12, 2'b11, 0, 0, 1,   1,  0,  0, 0, 0, 0, 3);
        add(  24, 2'b11, 0, 0, 1,   1,  1,  0, 0, 0, 0, 3);
        add(  25, 2'b11, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  26, 2'b10, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  40, 2'b11, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  42, 2'b01, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  48, 2'b01, 0, 0, 1,   1,  1,  1, 0, 0, 0, 3);
        add(  49, 2'b01, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  50, 2'b11, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  72, 2'b11, 0, 0, 1,   1,  1,  0, 0, 0, 0, 3);
        add(  74, 2'b00, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  80, 2'b11, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  94, 2'b01, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add(  96, 2'b01, 0, 0, 1,   1,  1,  1, 0, 0, 0, 3);
        add( 100, 2'b11, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add( 120, 2'b11, 0, 0, 1,   1,  1,  1, 1, 0, 0, 3);
        add( 144, 2'b11, 0, 0, 1,   1,  1,  0, 0, 0, 0, 3);
        add( 150, 2'b11, 1, 0, 1,   0,  0,  0, 0, 1, 0, 2);
        add( 156, 2'b11, 0, 0, 1,   1,  0,  0, 0, 1, 0, 2);
        add( 164, 2'b11, 0, 0, 1,   1,  0,  0, 0, 1, 0, 2);
        add( 172, 2'b11, 0, 0, 1,   1,  0,  0, 0, 0, 1, 2);
        add( 173, 2'b11, 0, 0, 1,   0,  0,  0, 0, 0, 0, 2);
        add( 180, 2'b11, 0, 0, 1,   1,  0,  0, 0, 0, 0, 2);
        add( 188, 2'b11, 0, 0, 1,   1,  1,  0, 0, 0, 0, 2);
        add( 190, 2'b11, 1, 0, 1,   0,  0,  0, 0, 1, 0, 2);
        add( 212, 2'b11, 0, 0, 1,   1,  0,  0, 0, 0, 1, 2);
        add( 214, 2'b11, 1, 1, 1,   0,  0,  0, 0, 1, 0, 3);
        add( 222, 2'b10, 0, 0, 1,   0,  0,  0, 0, 1, 0, 3);
        add( 226, 2'b11, 0, 0, 1,   0,  0,  0, 0, 1, 0, 3);
        add( 230, 2'b11, 1, 0, 1,   0,  0,  0, 0, 1, 0, 3);
        add( 232, 2'b11, 0, 0, 1,   1,  0,  0, 0, 1, 0, 3);
        add( 244, 2'b11, 0, 0, 1,   1,  0,  0, 0, 0, 1, 3);
        add( 256, 2'b11, 0, 0, 1,   1,  0,  0, 0, 0, 0, 3);
        add( 268, 2'b11, 0, 0, 1,   1,  1,  0, 0, 0, 0, 3);
        add( 270, 2'b11, 1, 0, 1,   0,  0,  0, 0, 1, 0, 2);
        add( 280, 2'b11, 0, 0, 0,   0,  0,  0, 0, 0, 0, 3);
        add( 291, 2'b11, 0, 0, 1,   0,  0,  0, 0, 0, 0, 3);
        add( 292, 2'b11, 0, 0, 1,   1,  0,  0, 0, 0, 0, 3);
        add( 304, 2'b11, 0, 0, 1,   1,  1,  0, 0, 0, 0, 3);

        KEY = 2'b11; win_evt = 0; lose_evt = 0; rstn = 0;
        repeat (3) @(negedge clk);
        rstn = 1;
        idx = 0;
        for (int c = 1; c <= 304; c++) begin
            logic hit;
            hit = (idx < tbl.size()) && (tbl[idx].cyc == c);
            if (hit) begin
                KEY = tbl[idx].key; win_evt = tbl[idx].win;
                lose_evt = tbl[idx].lose; rstn = tbl[idx].rstn;
            end else begin
                win_evt = 0; lose_evt = 0; rstn = 1;
            end
            @(negedge clk);
            if (hit) begin
                got = {sub_tick, move_tick, turn_valid, msg_active, msg_clear, delay_cur};
                exp = {tbl[idx].sub, tbl[idx].mov, tbl[idx].tv, tbl[idx].ma, tbl[idx].mc, tbl[idx].dly};
                checks++;
                if (got !== exp || (tbl[idx].tv && turn_dir !== tbl[idx].td)) begin
                    errors++;
                    $display("FAIL vec cyc=%0d got sub/mov/tv/ma/mc/dly=%b dir=%b, expected %b dir=%b",
                             c, got, turn_dir, exp, tbl[idx].td);
                end
                idx++;
            end
        end
        win_evt = 0; lose_evt = 0; rstn = 1;

        // Sub-tick period right after a move tick at delay 3 must be 12 clocks.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sub_tick && n < 50);
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL sub_period got %0d clocks, expected 12", n);
        end

        // A key held down across several moves yields exactly one turn.
        KEY = 2'b10;
        n = 0; mt = 0; tvc = 0;
        while (mt < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (move_tick) mt++;
            if (turn_valid) tvc++;
        end
        checks++;
        if (mt != 3) begin
            errors++;
            $display("FAIL held_key_moves got %0d move ticks, expected 3", mt);
        end
        checks++;
        if (tvc != 1) begin
            errors++;
            $display("FAIL held_key_turns got %0d turns, expected 1", tvc);
        end
        KEY = 2'b11;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_tick_scheduler.md
Name: snake_tick_scheduler

Overview:
- Central timing and control sequencer for the snake game datapath.
- Generates the blink sub-tick and the snake move tick from the board clock, with a programmable, level-dependent delay.
- Arbitrates the two direction keys into at most one turn request per move.
- Runs the play/message-hold state machine that freezes the datapath while the "COOL" or "U LOSE" message is shown.

Parameters:
- UNIT_CYCLES, 20000, clocks per delay unit.
- DELAY_INIT, 20, delay units per sub-tick at reset and after a loss.
- DELAY_MIN, 10, floor for the delay after level wins.
- BLINK_DIV, 5, sub-ticks per move tick.
- HOLD_TICKS, 20, sub-ticks the end message is held.
- DELAY_W, 8, width of the delay value.

Ports:
- clockInp  in  1  board clock
- resetInp_n  in  1  synchronous active-low reset
- KEY  in  2  raw keys, active low; KEY[0] = turn right, KEY[1] = turn left
- lose_evt  in  1  one-cycle pulse from datapath: snake crossed itself
- win_evt  in  1  one-cycle pulse from datapath: target length reached
- sub_tick  out  1  one-cycle strobe, drives apple blink
- move_tick  out  1  one-cycle strobe, datapath advances snake
- turn_valid  out  1  a turn is attached to this move_tick
- turn_dir  out  1  0 = right, 1 = left; meaningful only with turn_valid
- msg_active  out  1  high while the end message is held; datapath must not move
- msg_clear  out  1  one-cycle pulse at end of hold; datapath blanks HEX
- delay_cur  out  DELAY_W  current delay value

Behaviour:
- One clock domain (clockInp). Reset is synchronous and active-low (resetInp_n), sampled on posedge clockInp.
- Reset values:
  - sub_tick, move_tick, turn_valid, turn_dir, msg_active, msg_clear = 0.
  - delay_cur = DELAY_INIT; all counters = 0; FSM = PLAY; turn latch empty.
- Prescaler:
  - unit_cnt counts 0..UNIT_CYCLES-1; its wrap increments dly_cnt.
  - When dly_cnt reaches delay_cur-1 and unit_cnt wraps, sub_tick pulses for 1 cycle and both counters clear.
  - Sub-tick period = UNIT_CYCLES*delay_cur clocks exactly.
  - A delay_cur change takes effect from the next sub-tick period; the period in flight is not shortened.
- Move divider:
  - blink_cnt counts sub_ticks modulo BLINK_DIV, in PLAY only.
  - move_tick is asserted in the same cycle as the sub_tick that wraps blink_cnt to 0.
- Key path:
  - KEY passes through a 2-flop synchroniser, then a falling-edge detect per key.
  - A press is accepted only if the turn latch is empty and the FSM is PLAY.
  - Simultaneous edges on both keys: KEY[0] (right) wins and KEY[1] is dropped.
  - Further presses are ignored until the latch empties.
  - On move_tick: turn_valid = latch full, turn_dir = latched direction. The latch clears in the same cycle.
  - A press landing on the move_tick cycle is latched for the next move.
  - Keys held down do not repeat; a new falling edge is required.
- FSM states:
  - PLAY → HOLD on lose_evt or win_evt.
  - HOLD → PLAY when hold_cnt reaches HOLD_TICKS sub-ticks.
  - If lose_evt and win_evt arrive together, lose takes priority.
- Entering HOLD:
  - msg_active = 1 from the next cycle; hold_cnt = 0; blink_cnt = 0; turn latch cleared.
  - win: delay_cur -= 1 if delay_cur > DELAY_MIN, else unchanged.
  - lose: delay_cur = DELAY_INIT.
- In HOLD:
  - move_tick is suppressed; sub_tick keeps running; hold_cnt increments on each sub_tick.
  - lose_evt and win_evt are ignored.
- Exit from HOLD: msg_clear pulses for 1 cycle together with the deassertion of msg_active, then the FSM returns to PLAY. The first move_tick comes BLINK_DIV sub-ticks later.
- Arithmetic: counters are unsigned and sized by $clog2 of their maxima. delay_cur never goes below DELAY_MIN or above DELAY_INIT.
- Reset mid-operation (any state, any count) returns everything to the reset values on the next edge.

Optional Feature:
- Macro: SNAKE_KEY_DEBOUNCE_EN.
- Defined: a 16-bit stability counter per key after the synchroniser. A key level is accepted only after 50000 consecutive equal samples, and edge detection runs on the filtered level. Adds 50000+2 clocks of key latency.
- Undefined: edge detection runs directly on the synchronised level (2-clock latency).

Test Plan:
Bench parameters: UNIT_CYCLES=4, DELAY_INIT=3, DELAY_MIN=2, BLINK_DIV=2, HOLD_TICKS=3.
1. Release reset, hold keys high → sub_tick every 12 clocks; move_tick on every 2nd sub_tick (every 24 clocks); turn_valid stays 0.
2. Pulse KEY[0] low for 1 move period, then press KEY[1] in the same period → next move_tick has turn_valid=1, turn_dir=0; the following move_tick has turn_valid=0.
3. Drive the KEY[1:0] falling edge in the same cycle → turn_dir=0. Press exactly on the move_tick cycle → the turn appears on the next move_tick.
4. win_evt pulse → msg_active=1, delay_cur=2, no move_tick for 3 sub-ticks (24 clocks), then msg_clear pulse. Second win_evt → delay_cur stays 2.
5. lose_evt and win_evt in the same cycle while delay_cur=2 → delay_cur=3. Keys pressed during HOLD are ignored; no turn_valid after resume.
6. Assert resetInp_n=0 mid-HOLD for 1 cycle → msg_active=0, delay_cur=3, FSM in PLAY, next sub_tick 12 clocks after release.
